// File: rtl/wt8_share_arb.sv
// Round-robin arbiter sharing one WT_8b multiplier among 4 requesters, with a
// 1-deep registered response. Define WT8_ARB_FIXED_PRIO_EN for fixed priority.
module wt8_share_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [1:0]          rsp_id,
  output logic [2*W-1:0]      rsp_prod,
  input  logic                rsp_ready,
  output logic                busy
);

  localparam int unsigned IDW = 2;
  localparam int unsigned PW  = 2 * W;

  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [PW-1:0]   r_rsp_prod;

  logic            w_can_accept;
  logic            w_gnt_any;
  logic [IDW-1:0]  w_gnt_idx;
  logic            w_accept;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic [PW-1:0]   w_prod;

  assign w_can_accept = ~r_rsp_valid | rsp_ready;

`ifdef WT8_ARB_FIXED_PRIO_EN
  // Lowest set index wins; scanning downward leaves the lowest as the final pick.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_idx;

  // Search from ptr+1 (2-bit wrap gives mod 4); nearest offset is assigned last.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int k = int'(NREQ); k >= 1; k--) begin
      w_idx = r_ptr + IDW'(k);
      if (req_valid[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IDW'(NREQ - 1);
    end else if (w_accept) begin
      r_ptr <= w_gnt_idx;
    end
  end
`endif

  assign w_accept  = w_gnt_any & w_can_accept & ~rst;
  assign req_ready = w_accept ? (NREQ'(1) << w_gnt_idx) : '0;

  assign w_a = req_a[{w_gnt_idx, 3'b000} +: W];
  assign w_b = req_b[{w_gnt_idx, 3'b000} +: W];

  WT_8b u_mul (
    .a (w_a),
    .b (w_b),
    .p (w_prod)
  );

  // Response register: load on accept, clear valid on drain, data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_prod  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt_idx;
      r_rsp_prod  <= w_prod;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_prod  = r_rsp_prod;
  assign busy      = (r_rsp_valid & ~rst) | (|req_valid);

endmodule

// 8x8 unsigned Wallace-tree multiplier: partial products reduced by 3:2 CSA
// layers down to two rows, then one carry-propagate add.
module WT_8b (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  function automatic logic [15:0] csa_s(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_c(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [15:0] w_pp [8];
  logic [15:0] w_s0, w_c0, w_s1, w_c1, w_s2, w_c2, w_s3, w_c3;
  logic [15:0] w_s4, w_c4, w_s5, w_c5;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_pp[i] = 16'({8{b[i]}} & a) << i;
    end
  end

  // 8 -> 6 -> 4 -> 3 -> 2 rows
  assign w_s0 = csa_s(w_pp[0], w_pp[1], w_pp[2]);
  assign w_c0 = csa_c(w_pp[0], w_pp[1], w_pp[2]);
  assign w_s1 = csa_s(w_pp[3], w_pp[4], w_pp[5]);
  assign w_c1 = csa_c(w_pp[3], w_pp[4], w_pp[5]);
  assign w_s2 = csa_s(w_s0, w_c0, w_s1);
  assign w_c2 = csa_c(w_s0, w_c0, w_s1);
  assign w_s3 = csa_s(w_c1, w_pp[6], w_pp[7]);
  assign w_c3 = csa_c(w_c1, w_pp[6], w_pp[7]);
  assign w_s4 = csa_s(w_s2, w_c2, w_s3);
  assign w_c4 = csa_c(w_s2, w_c2, w_s3);
  assign w_s5 = csa_s(w_s4, w_c4, w_c3);
  assign w_c5 = csa_c(w_s4, w_c4, w_c3);

  assign p = w_s5 + w_c5;

endmodule

// File: tb/tb_wt8_share_arb.sv
// Scoreboard bench for wt8_share_arb: stimulus pushes hand-computed responses,
// a negedge monitor pops and compares them on each response handshake.
module tb_wt8_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_prod;
  logic        rsp_ready;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  logic [17:0] q_exp [$];

  always #5 clk = ~clk;

  wt8_share_arb dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (q_exp.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got id %0d prod %0h expected no response", rsp_id, rsp_prod);
      end else begin
        logic [17:0] e;
        e = q_exp.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(e[17:16]));
        check("rsp_prod", 32'(rsp_prod), 32'(e[15:0]));
      end
    end
  end

  // One cycle of stimulus; push expected response when an accept is expected.
  task automatic drive(input logic [3:0] v, input logic rr, input logic [3:0] exp_rdy,
                       input logic [1:0] exp_id, input logic [15:0] exp_prod);
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_rdy != 4'b0000) q_exp.push_back({exp_id, exp_prod});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    rst = 1'b1;
    req_valid = v;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'(|v));
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'b0000;
    q_exp.delete();
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_prod", 32'(rsp_prod), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prods [4];
    logic [1:0]  eid;
    prods[0] = 16'd200; prods[1] = 16'd231; prods[2] = 16'd264; prods[3] = 16'd299;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(4'b1111);

    // Single transfer 12 x 13
    req_a = {8'd0, 8'd0, 8'd0, 8'd12};
    req_b = {8'd0, 8'd0, 8'd0, 8'd13};
    drive(4'b0001, 1'b1, 4'b0001, 2'd0, 16'd156);
    drive(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0);
    @(negedge clk);
    check("drained_valid", 32'(rsp_valid), 32'd0);
    check("drained_prod_hold", 32'(rsp_prod), 32'd156);
    @(posedge clk); #1;

    // All requesting, sustained throughput
    do_reset(4'b0000);
    req_a = {8'd13, 8'd12, 8'd11, 8'd10};
    req_b = {8'd23, 8'd22, 8'd21, 8'd20};
    for (int k = 0; k < 5; k++) begin
`ifdef WT8_ARB_FIXED_PRIO_EN
      eid = 2'd0;
`else
      eid = 2'(k % 4);
`endif
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      @(negedge clk);
      if (k > 0) check("rsp_valid_sustained", 32'(rsp_valid), 32'd1);
      check("rr_req_ready", 32'(req_ready), 32'(4'b0001 << eid));
      q_exp.push_back({eid, prods[eid]});
      @(posedge clk); #1;
    end
    drive(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0);

    // 255 x 255 on requester 3, then hold it with back-pressure
    req_a = {8'd255, 8'd7, 8'd0, 8'd0};
    req_b = {8'd255, 8'd9, 8'd0, 8'd0};
    drive(4'b1000, 1'b0, 4'b1000, 2'd3, 16'hFE01);
    for (int k = 0; k < 5; k++) begin
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rsp_prod", 32'(rsp_prod), 32'hFE01);
      if (k == 0) check("hold_rsp_id", 32'(rsp_id), 32'd3);
      @(posedge clk); #1;
    end
    drive(4'b0100, 1'b1, 4'b0100, 2'd2, 16'd63);
    drive(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0);

    // Reset while a product is held discards it
    req_a = {8'd0, 8'd0, 8'd0, 8'd5};
    req_b = {8'd0, 8'd0, 8'd0, 8'd6};
    drive(4'b0001, 1'b0, 4'b0001, 2'd0, 16'd30);
    do_reset(4'b0000);
    req_a = {8'd13, 8'd12, 8'd11, 8'd10};
    req_b = {8'd23, 8'd22, 8'd21, 8'd20};
    drive(4'b1111, 1'b1, 4'b0001, 2'd0, 16'd200);
    drive(4'b0000, 1'b1, 4'b0000, 2'd0, 16'd0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(q_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
